// File: rtl/normalizer.sv
// Five-stage 32-bit normalizer: left mode shifts the leading one to bit 31
// (leading-zero count), right mode shifts the lowest one to bit 0 (trailing-zero count).
module normalizer (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic        in_valid,
   input  logic [31:0] x,
   input  logic        dir,
   output logic [31:0] y,
   output logic [5:0]  cnt,
   output logic        zero,
   output logic        out_valid,
   output logic        dir_out
);

   // One stage: if the k bits about to be shifted out are all zero, shift by k
   // and set count bit k. Returns {count, value}.
   function automatic logic [36:0] norm_stage(input logic [31:0] v,
                                              input logic [4:0]  c,
                                              input logic        d,
                                              input logic [4:0]  k);
      logic [31:0] top_mask;
      logic [31:0] bot_mask;
      logic        hit;
      top_mask = ~(32'hFFFF_FFFF >> k);
      bot_mask = ~(32'hFFFF_FFFF << k);
      hit      = d ? ((v & top_mask) == 32'd0) : ((v & bot_mask) == 32'd0);
      if (hit)
         return {c | k, (d ? (v << k) : (v >> k))};
      else
         return {c, v};
   endfunction

   logic [31:0] r_val  [0:3];
   logic [4:0]  r_cnt  [0:3];
   logic [3:0]  r_dir;
   logic [3:0]  r_zero;
   logic [3:0]  r_vld;

   logic [31:0] w_val  [0:4];
   logic [4:0]  w_cnt  [0:4];

   always_comb begin
      {w_cnt[0], w_val[0]} = norm_stage(x,        5'd0,     dir,      5'd16);
      {w_cnt[1], w_val[1]} = norm_stage(r_val[0], r_cnt[0], r_dir[0], 5'd8);
      {w_cnt[2], w_val[2]} = norm_stage(r_val[1], r_cnt[1], r_dir[1], 5'd4);
      {w_cnt[3], w_val[3]} = norm_stage(r_val[2], r_cnt[2], r_dir[2], 5'd2);
      {w_cnt[4], w_val[4]} = norm_stage(r_val[3], r_cnt[3], r_dir[3], 5'd1);
   end

   // NOTE: non-blocking assignments so every stage samples its neighbour's
   // pre-edge value; blocking here would collapse the pipeline into one cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         // NOTE: the pipeline arrays are small register banks, not RAM, so they
         // are reset along with the valid bits to keep outputs deterministic.
         for (int s = 0; s < 4; s++) begin
            r_val[s] <= '0;
            r_cnt[s] <= '0;
         end
         r_dir     <= '0;
         r_zero    <= '0;
         r_vld     <= '0;
         y         <= '0;
         cnt       <= '0;
         zero      <= 1'b0;
         out_valid <= 1'b0;
         dir_out   <= 1'b0;
      end else if (en) begin
         r_val[0]  <= w_val[0];
         r_cnt[0]  <= w_cnt[0];
         r_dir[0]  <= dir;
         r_zero[0] <= (x == 32'd0);
         r_vld[0]  <= in_valid;
         for (int s = 1; s < 4; s++) begin
            r_val[s]  <= w_val[s];
            r_cnt[s]  <= w_cnt[s];
            r_dir[s]  <= r_dir[s-1];
            r_zero[s] <= r_zero[s-1];
            r_vld[s]  <= r_vld[s-1];
         end
         // A zero operand reports the full width rather than the 31 the stages accumulate.
         y         <= r_zero[3] ? 32'd0 : w_val[4];
         cnt       <= r_zero[3] ? 6'd32 : {1'b0, w_cnt[4]};
         zero      <= r_zero[3];
         out_valid <= r_vld[3];
         dir_out   <= r_dir[3];
      end
   end

endmodule

// File: tb/tb_normalizer.sv
// Directed and randomized checks for normalizer against a lockstep reference
// pipeline built from a bit-by-bit shift model.
module tb_normalizer;

   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic        in_valid;
   logic [31:0] x;
   logic        dir;
   logic [31:0] y;
   logic [5:0]  cnt;
   logic        zero;
   logic        out_valid;
   logic        dir_out;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic        valid;
      logic [31:0] y;
      logic [5:0]  cnt;
      logic        zero;
      logic        dir;
   } result_t;

   result_t pipe [0:4];

   normalizer dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .in_valid  (in_valid),
      .x         (x),
      .dir       (dir),
      .y         (y),
      .cnt       (cnt),
      .zero      (zero),
      .out_valid (out_valid),
      .dir_out   (dir_out)
   );

   always #5 clk = ~clk;

   function automatic result_t ref_norm(input logic v, input logic [31:0] xv, input logic d);
      result_t     r;
      logic [31:0] t;
      int          n;
      r.valid = v;
      r.dir   = d;
      if (xv == 32'd0) begin
         r.y    = 32'd0;
         r.cnt  = 6'd32;
         r.zero = 1'b1;
      end else begin
         t = xv;
         n = 0;
         if (d) begin
            while (!t[31]) begin t = t << 1; n++; end
         end else begin
            while (!t[0]) begin t = t >> 1; n++; end
         end
         r.y    = t;
         r.cnt  = 6'(n);
         r.zero = 1'b0;
      end
      return r;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic clear_model();
      for (int i = 0; i < 5; i++) pipe[i] = '{1'b0, 32'd0, 6'd0, 1'b0, 1'b0};
   endtask

   // Drive one cycle, advance the reference pipe on enabled edges, compare after the edge.
   task automatic step(input logic e, input logic v, input logic [31:0] xv, input logic d);
      en = e; in_valid = v; x = xv; dir = d;
      @(posedge clk);
      if (e) begin
         for (int i = 4; i > 0; i--) pipe[i] = pipe[i-1];
         pipe[0] = ref_norm(v, xv, d);
      end
      #1;
      check("out_valid", {31'd0, out_valid}, {31'd0, pipe[4].valid});
      if (pipe[4].valid) begin
         check("y",       y,                  pipe[4].y);
         check("cnt",     {26'd0, cnt},       {26'd0, pipe[4].cnt});
         check("zero",    {31'd0, zero},      {31'd0, pipe[4].zero});
         check("dir_out", {31'd0, dir_out},   {31'd0, pipe[4].dir});
      end
   endtask

   task automatic expect_out(input string tag, input logic ev, input logic [31:0] ey,
                             input logic [5:0] ec, input logic ez, input logic ed);
      check({tag, ".valid"}, {31'd0, out_valid}, {31'd0, ev});
      check({tag, ".y"},     y,                  ey);
      check({tag, ".cnt"},   {26'd0, cnt},       {26'd0, ec});
      check({tag, ".zero"},  {31'd0, zero},      {31'd0, ez});
      check({tag, ".dir"},   {31'd0, dir_out},   {31'd0, ed});
   endtask

   initial begin
      logic [31:0] rx;
      rst = 1'b1; en = 1'b0; in_valid = 1'b0; x = '0; dir = 1'b0;
      clear_model();
      #12 rst = 1'b0;
      expect_out("reset", 1'b0, 32'd0, 6'd0, 1'b0, 1'b0);

      // Left mode back-to-back
      step(1, 1, 32'h0000_0001, 1);
      step(1, 1, 32'h00F0_0000, 1);
      step(1, 1, 32'h8000_0000, 1);
      step(1, 1, 32'hFFFF_FFFF, 1);
      step(1, 0, 32'h0, 0); expect_out("l_one",  1, 32'h8000_0000, 6'd31, 0, 1);
      step(1, 0, 32'h0, 0); expect_out("l_f0",   1, 32'hF000_0000, 6'd8,  0, 1);
      step(1, 0, 32'h0, 0); expect_out("l_msb",  1, 32'h8000_0000, 6'd0,  0, 1);
      step(1, 0, 32'h0, 0); expect_out("l_ones", 1, 32'hFFFF_FFFF, 6'd0,  0, 1);

      // Right mode and zero operands in both modes
      step(1, 1, 32'h00F0_0000, 0);
      step(1, 1, 32'h8000_0000, 0);
      step(1, 1, 32'h0000_0003, 0);
      step(1, 1, 32'h0000_0000, 1);
      step(1, 1, 32'h0000_0000, 0); expect_out("r_f0",   1, 32'h0000_000F, 6'd20, 0, 0);
      step(1, 0, 32'h0, 0);         expect_out("r_msb",  1, 32'h0000_0001, 6'd31, 0, 0);
      step(1, 0, 32'h0, 0);         expect_out("r_3",    1, 32'h0000_0003, 6'd0,  0, 0);
      step(1, 0, 32'h0, 0);         expect_out("z_left", 1, 32'h0000_0000, 6'd32, 1, 1);
      step(1, 0, 32'h0, 0);         expect_out("z_rght", 1, 32'h0000_0000, 6'd32, 1, 0);
      step(1, 0, 32'h0, 0);         expect_out("drain",  0, 32'h0000_0000, 6'd32, 1, 0);

      // Stream with gaps, alternating dir, and a 3-cycle en stall mid-stream
      step(1, 1, 32'h1234_5678, 1);
      step(1, 1, 32'h0000_0100, 0);
      step(1, 0, 32'hDEAD_BEEF, 1);
      step(1, 1, 32'h0008_0000, 1);
      step(1, 1, 32'hC000_0000, 0);
      step(0, 1, 32'h5555_5555, 1);
      step(0, 1, 32'hAAAA_AAAA, 0);
      step(0, 1, 32'h0000_0001, 1);
      step(1, 1, 32'h0000_8000, 0);
      step(1, 0, 32'h0F00_0000, 1);
      step(1, 1, 32'h0000_0000, 1);
      step(1, 1, 32'h7FFF_FFFF, 0);
      step(1, 1, 32'h0000_0040, 1);
      for (int i = 0; i < 6; i++) step(1, 0, 32'h0, 0);

      // Async reset with four operands in flight
      step(1, 1, 32'h0000_0010, 1);
      step(1, 1, 32'h0100_0000, 0);
      step(1, 1, 32'h0000_0F00, 1);
      step(1, 1, 32'h0003_0000, 0);
      #2 rst = 1'b1;
      #1 expect_out("rst_mid", 0, 32'd0, 6'd0, 0, 0);
      clear_model();
      @(posedge clk);
      #2 rst = 1'b0;
      step(1, 1, 32'h0001_0000, 1);
      for (int i = 0; i < 3; i++) step(1, 0, 32'h0, 0);
      step(1, 0, 32'h0, 0); expect_out("post_rst", 1, 32'h8000_0000, 6'd15, 0, 1);

      // Randomized stream against the reference pipe
      for (int i = 0; i < 3000; i++) begin
         rx = $urandom & ($urandom >> $urandom_range(0, 31));
         if ($urandom_range(0, 15) == 0) rx = 32'd0;
         step(($urandom_range(0, 4) != 0), 1'($urandom), rx, 1'($urandom));
      end
      for (int i = 0; i < 6; i++) step(1, 0, 32'h0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
